// File: rtl/cfg_shadow_bank.sv
// Multi-channel configuration-constant bank: software writes a shadow copy, which is copied to the active copy on a commit aligned to a sync strobe.
// Optional readback port guarded by CFG_SHADOW_BANK_READBACK_EN.
module cfg_shadow_bank #(
    parameter int unsigned N          = 4,
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned INIT_VALUE = 0,
    parameter int unsigned INIT_STEP  = 0,
    localparam int unsigned ADDR_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic                 i_commit,
    input  logic                 i_sync,
    input  logic                 i_restore,
    output logic                 o_pending,
    output logic                 o_commit_done,
    output logic                 o_err,
`ifdef CFG_SHADOW_BANK_READBACK_EN
    input  logic [ADDR_W-1:0]    i_rd_addr,
    output logic [WIDTH-1:0]     o_rd_shadow,
    output logic                 o_rd_diff,
`endif
    output logic [N*WIDTH-1:0]   o_active
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    typedef logic [N-1:0][WIDTH-1:0] bank_t;

    // Per-channel default: (INIT_VALUE + k*INIT_STEP) in 32-bit arithmetic, truncated to WIDTH
    function automatic bank_t init_defaults();
        bank_t       d;
        logic [31:0] v;
        d = '0;
        for (int unsigned k = 0; k < N; k++) begin
            v = 32'(INIT_VALUE) + 32'(k) * 32'(INIT_STEP);
            d[ADDR_W'(k)] = WIDTH'(v);
        end
        return d;
    endfunction

    localparam bank_t DEFAULTS = init_defaults();

    state_t state_q;
    state_t state_d;
    bank_t  shadow_q;
    bank_t  active_q;
    bank_t  shadow_fwd_c;
    logic   xfer_c;
    logic   wr_fire_c;
    logic   wr_in_range_c;

    assign wr_in_range_c = 32'(i_wr_addr) < N;
    assign wr_fire_c     = i_wr_valid && (state_q == ST_IDLE) && !i_restore;

    // Next-state and transfer decision; restore overrides any commit/sync activity
    always_comb begin
        state_d = state_q;
        xfer_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_commit) begin
                    if (i_sync) begin
                        xfer_c = 1'b1;
                    end else begin
                        state_d = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (i_sync) begin
                    xfer_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (i_restore) begin
            state_d = ST_IDLE;
            xfer_c  = 1'b0;
        end
    end

    // Shadow image including this cycle's write, so a same-cycle commit picks it up
    always_comb begin
        shadow_fwd_c = shadow_q;
        if (wr_fire_c && wr_in_range_c) begin
            shadow_fwd_c[i_wr_addr] = i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restore) begin
            shadow_q <= DEFAULTS;
            active_q <= DEFAULTS;
        end else begin
            shadow_q <= shadow_fwd_c;
            if (xfer_c) begin
                active_q <= shadow_fwd_c;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wr_ready    <= 1'b1;
            o_pending     <= 1'b0;
            o_commit_done <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_wr_ready    <= (state_d == ST_IDLE);
            o_pending     <= (state_d == ST_PENDING);
            o_commit_done <= xfer_c;
            if (i_restore) begin
                o_err <= 1'b0;
            end else if (wr_fire_c && !wr_in_range_c) begin
                o_err <= 1'b1;
            end
        end
    end

    assign o_active = active_q;

`ifdef CFG_SHADOW_BANK_READBACK_EN
    logic rd_in_range_c;
    assign rd_in_range_c = 32'(i_rd_addr) < N;

    // Registered readback of the shadow and its divergence from the active copy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_shadow <= '0;
            o_rd_diff   <= 1'b0;
        end else if (rd_in_range_c) begin
            o_rd_shadow <= shadow_q[i_rd_addr];
            o_rd_diff   <= (shadow_q[i_rd_addr] != active_q[i_rd_addr]);
        end else begin
            o_rd_shadow <= '0;
            o_rd_diff   <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cfg_shadow_bank.sv
// Self-checking bench for cfg_shadow_bank: directed scenarios plus random traffic against a behavioural model.
// Connects the readback ports when CFG_SHADOW_BANK_READBACK_EN is defined.
module tb_cfg_shadow_bank;

    localparam int unsigned NA = 5;
    localparam int unsigned WA = 10;
    localparam int unsigned IV = 5;
    localparam int unsigned IS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wr_valid, commit, sync, restore;
    logic [2:0]    wr_addr;
    logic [WA-1:0] wr_data;
    logic          wr_ready, pending, commit_done, err;
    logic [NA*WA-1:0] active;

    logic          b_wr_ready, b_pending, b_done, b_err;
    logic [15:0]   b_active;

`ifdef CFG_SHADOW_BANK_READBACK_EN
    logic [2:0]    rd_addr;
    logic [WA-1:0] rd_shadow;
    logic          rd_diff;
    logic [WA-1:0] m_rd_shadow;
    logic          m_rd_diff;
    logic [1:0]    b_rd_shadow_unused4;
    logic [3:0]    b_rd_shadow;
    logic          b_rd_diff;
`endif

    cfg_shadow_bank #(.N(NA), .WIDTH(WA), .INIT_VALUE(IV), .INIT_STEP(IS)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_commit(commit), .i_sync(sync), .i_restore(restore),
        .o_pending(pending), .o_commit_done(commit_done), .o_err(err),
`ifdef CFG_SHADOW_BANK_READBACK_EN
        .i_rd_addr(rd_addr), .o_rd_shadow(rd_shadow), .o_rd_diff(rd_diff),
`endif
        .o_active(active)
    );

    // Wrap-around defaults instance: WIDTH=4, INIT_VALUE=14, INIT_STEP=1
    cfg_shadow_bank #(.N(4), .WIDTH(4), .INIT_VALUE(14), .INIT_STEP(1)) dut_wrap (
        .i_clk(clk), .i_rst(rst),
        .i_wr_valid(1'b0), .o_wr_ready(b_wr_ready),
        .i_wr_addr(2'd0), .i_wr_data(4'd0),
        .i_commit(1'b0), .i_sync(1'b0), .i_restore(1'b0),
        .o_pending(b_pending), .o_commit_done(b_done), .o_err(b_err),
`ifdef CFG_SHADOW_BANK_READBACK_EN
        .i_rd_addr(2'd0), .o_rd_shadow(b_rd_shadow), .o_rd_diff(b_rd_diff),
`endif
        .o_active(b_active)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    int unsigned m_shadow [NA];
    int unsigned m_active [NA];
    bit m_pend, m_err, m_done;

    function automatic int unsigned dflt(int unsigned k, int unsigned iv, int unsigned st, int unsigned w);
        return (iv + k * st) % (32'd1 << w);
    endfunction

    function automatic logic [63:0] pack_active();
        logic [63:0] v = '0;
        for (int k = 0; k < NA; k++) v[k*WA +: WA] = WA'(m_active[k]);
        return v;
    endfunction

    task automatic model_defaults();
        for (int k = 0; k < NA; k++) begin
            m_shadow[k] = dflt(k, IV, IS, WA);
            m_active[k] = m_shadow[k];
        end
    endtask

    task automatic model_edge();
`ifdef CFG_SHADOW_BANK_READBACK_EN
        if (rst) begin
            m_rd_shadow = '0;
            m_rd_diff   = 1'b0;
        end else if (rd_addr < NA) begin
            m_rd_shadow = WA'(m_shadow[rd_addr]);
            m_rd_diff   = m_shadow[rd_addr] != m_active[rd_addr];
        end else begin
            m_rd_shadow = '0;
            m_rd_diff   = 1'b0;
        end
`endif
        if (rst || restore) begin
            model_defaults();
            m_pend = 0;
            m_err  = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (!m_pend && wr_valid) begin
                if (wr_addr < NA) m_shadow[wr_addr] = wr_data;
                else              m_err = 1;
            end
            if (!m_pend && commit) begin
                if (sync) begin
                    m_active = m_shadow;
                    m_done   = 1;
                end else begin
                    m_pend = 1;
                end
            end else if (m_pend && sync) begin
                m_active = m_shadow;
                m_pend   = 0;
                m_done   = 1;
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        chk({ctx, ":active"},   64'(active),      pack_active());
        chk({ctx, ":pending"},  64'(pending),     64'(m_pend));
        chk({ctx, ":wr_ready"}, 64'(wr_ready),    64'(!m_pend));
        chk({ctx, ":done"},     64'(commit_done), 64'(m_done));
        chk({ctx, ":err"},      64'(err),         64'(m_err));
`ifdef CFG_SHADOW_BANK_READBACK_EN
        chk({ctx, ":rd_shadow"}, 64'(rd_shadow), 64'(m_rd_shadow));
        chk({ctx, ":rd_diff"},   64'(rd_diff),   64'(m_rd_diff));
`endif
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare just after it
    task automatic step(input string ctx, input bit r, input bit wv, input int unsigned wa,
                        input int unsigned wd, input bit cm, input bit sy, input bit rs);
        rst      = r;
        wr_valid = wv;
        wr_addr  = 3'(wa);
        wr_data  = WA'(wd);
        commit   = cm;
        sync     = sy;
        restore  = rs;
`ifdef CFG_SHADOW_BANK_READBACK_EN
        rd_addr  = 3'($urandom_range(0, 7));
`endif
        @(posedge clk);
        model_edge();
        #1;
        compare_all(ctx);
    endtask

    logic [63:0] exp_rst;
    logic [15:0] exp_wrap;

    initial begin
        m_pend = 0;
        m_err  = 0;
        m_done = 0;
        model_defaults();

        step("reset0", 1, 0, 0, 0, 0, 0, 0);
        step("reset1", 1, 0, 0, 0, 0, 0, 0);
        exp_rst = 64'(5) | (64'(8) << 10) | (64'(11) << 20) | (64'(14) << 30) | (64'(17) << 40);
        chk("reset_defaults", 64'(active), exp_rst);
        chk("reset_ready", 64'(wr_ready), 64'd1);
        exp_wrap = '0;
        for (int k = 0; k < 4; k++) exp_wrap[k*4 +: 4] = 4'(dflt(k, 14, 1, 4));
        chk("wrap_defaults", 64'(b_active), 64'(exp_wrap));
        chk("wrap_defaults_const", 64'(b_active), 64'h10FE);
        step("idle0", 0, 0, 0, 0, 0, 0, 0);

        // Write ch2, commit without sync, hold, then sync
        step("wr_ch2", 0, 1, 2, 10'h3FF, 0, 0, 0);
        step("commit_nosync", 0, 0, 0, 0, 1, 0, 0);
        step("hold1", 0, 1, 0, 10'h155, 0, 0, 0);
        step("hold2", 0, 0, 0, 0, 1, 0, 0);
        chk("pending_held", 64'(pending), 64'd1);
        chk("ch2_unchanged", 64'(active[20 +: 10]), 64'd11);
        step("sync", 0, 0, 0, 0, 0, 1, 0);
        chk("ch2_committed", 64'(active[20 +: 10]), 64'h3FF);
        chk("ch0_not_written", 64'(active[0 +: 10]), 64'd5);
        step("post_sync", 0, 0, 0, 0, 0, 0, 0);
        chk("done_one_cycle", 64'(commit_done), 64'd0);

        // Same-cycle write + commit + sync
        step("wr_commit_sync", 0, 1, 1, 100, 1, 1, 0);
        chk("forward_ch1", 64'(active[10 +: 10]), 64'd100);
        step("after_fwd", 0, 0, 0, 0, 0, 1, 0);

        // Out-of-range write sets sticky error
        step("wr_oob", 0, 1, 6, 10'h2AA, 0, 0, 0);
        chk("err_set", 64'(err), 64'd1);
        step("commit_err", 0, 0, 0, 0, 1, 1, 0);
        step("err_sticky", 0, 0, 0, 0, 0, 0, 0);
        chk("err_sticky", 64'(err), 64'd1);

        // Restore while pending cancels commit and clears error
        step("wr_ch3", 0, 1, 3, 77, 0, 0, 0);
        step("commit_p", 0, 0, 0, 0, 1, 0, 0);
        step("restore", 0, 1, 0, 9, 1, 1, 1);
        chk("restore_defaults", 64'(active), exp_rst);
        chk("restore_err", 64'(err), 64'd0);
        step("restore_nodone", 0, 0, 0, 0, 0, 1, 0);
        chk("restore_no_done", 64'(commit_done), 64'd0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step("rand",
                 ($urandom_range(0, 199) == 0),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7),
                 $urandom,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cfg_shadow_bank.md
Name: cfg_shadow_bank

Overview:
- Parametrised multi-channel configuration-constant bank.
- Each channel resets to a compile-time default derived from parameters (INIT_VALUE, INIT_STEP).
- Software writes go into a shadow copy. Shadow values become active atomically only on a commit that is aligned to a sync strobe.
- Sits between the register interface and datapath blocks, which consume the active constants.

Parameters:
- N, 4, number of channels (1..64).
- WIDTH, 10, bits per channel.
- INIT_VALUE, 0, default value of channel 0.
- INIT_STEP, 0, default increment per channel index.
- ADDR_W, derived: max(1, clog2(N)), write address width (localparam).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; synchronous, active-high
- i_wr_valid  input  1  shadow write request
- o_wr_ready  output  1  shadow write accepted when high
- i_wr_addr  input  ADDR_W  channel index
- i_wr_data  input  WIDTH  write data
- i_commit  input  1  request shadow->active transfer
- i_sync  input  1  frame/sync strobe that gates the transfer
- i_restore  input  1  reload defaults into shadow and active
- o_pending  output  1  commit armed, waiting for sync
- o_commit_done  output  1  one-cycle pulse after the active bank updates
- o_err  output  1  sticky flag: a write was attempted to an out-of-range address
- o_active  output  N*WIDTH  active values; channel k occupies bits [k*WIDTH +: WIDTH]

Behaviour:
- Default for channel k: (INIT_VALUE + k*INIT_STEP) mod 2^WIDTH. Computed in 32-bit unsigned arithmetic, then truncated to WIDTH.
- Reset (i_rst=1 at a clock edge) sets:
  - shadow and active to defaults
  - FSM to IDLE
  - o_pending=0, o_commit_done=0, o_err=0
  - o_wr_ready=1 on the cycle after reset.
- FSM states: IDLE, PENDING.
- o_wr_ready = (state==IDLE). Shadow is frozen while PENDING. o_pending = (state==PENDING).
- Write handshake: a write is accepted when i_wr_valid && o_wr_ready.
  - i_wr_addr < N: shadow[i_wr_addr] <= i_wr_data.
  - i_wr_addr >= N: data is dropped and o_err <= 1 (sticky until reset or restore).
  - Writes while PENDING are not accepted; there is no error and no effect.
- IDLE, i_commit=1, i_sync=0: go to PENDING.
- IDLE, i_commit=1, i_sync=1: active <= shadow at this edge. Stay IDLE. o_commit_done=1 next cycle.
- PENDING, i_sync=1: active <= shadow, go to IDLE, o_commit_done=1 for exactly the next cycle.
- PENDING, i_commit=1 again: no effect (no double-queue).
- i_sync without a commit pending: no effect.
- A write accepted in the same cycle as the commit is included in the committed image. The shadow-to-active copy uses the post-write value (forwarding).
- Priority, highest first: i_rst, then i_restore, then commit/sync logic, then writes.
- i_restore=1:
  - shadow and active <= defaults, o_err <= 0, state <= IDLE.
  - A pending commit is cancelled, with no o_commit_done pulse.
  - Any write in the same cycle is discarded.
- Reset while PENDING: same as restore; the transfer is lost.
- Latency: o_active changes at the clock edge where the transfer occurs. It is registered, with no combinational path from inputs to o_active.

Optional Feature:
- Macro CFG_SHADOW_BANK_READBACK_EN.
- When defined, adds:
  - i_rd_addr  input  ADDR_W
  - o_rd_shadow  output  WIDTH, registered: shadow[i_rd_addr] one cycle later
  - o_rd_diff  output  1, registered: 1 when shadow and active differ at that address
- Out-of-range i_rd_addr returns 0 on both outputs.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan (N=4, WIDTH=10, INIT_VALUE=5, INIT_STEP=3 unless noted):
- Reset -> o_active channels = {5,8,11,14}; o_wr_ready=1; o_pending=0; o_err=0.
- Write ch2=0x3FF, then commit with i_sync low for 3 cycles -> o_pending=1, o_wr_ready=0, ch2 still 11. Then assert i_sync -> next edge ch2=0x3FF, o_commit_done pulses exactly 1 cycle, o_pending=0.
- Same-cycle write ch1=100, i_commit=1, i_sync=1 in IDLE -> o_active ch1=100 after that edge; o_commit_done=1 the next cycle.
- Write to addr 3 then to addr 5 with N=6 vs N=4 variant (N=4 using ADDR_W=2 impossible; use N=5, addr 6) -> addr 6 dropped, o_err=1 and stays 1 across commits.
- PENDING with shadow modified, assert i_restore -> o_active={5,8,11,14}, o_pending=0, no o_commit_done, o_err=0.
- Wrap: WIDTH=4, INIT_VALUE=14, INIT_STEP=1, N=4 -> defaults {14,15,0,1}.
